// File: rtl/sseg_scan_controller.sv
// sseg_scan_controller
//
// Purpose:
//   Time-multiplexes a multi-digit common-anode 7-segment display through a
//   single shared hex_to_7_segment decoder. Per-digit codes are
//   double-buffered. A new value is written into the pending buffer and only
//   becomes active at a frame boundary, so a frame never shows a mix of old
//   and new digits. Each digit slot starts with a short guard window with all
//   anodes off. This lets the decoder output settle before the anode turns on,
//   which avoids ghosting.
//
// Parameters:
//   NUM_DIGITS   number of digits scanned (2..8)
//   REFRESH_DIV  clock cycles per digit slot (>= GUARD+2)
//   GUARD        cycles at the start of each slot with all anodes off
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   digits_i     digit codes, digit k = [8k+7:8k], digit 0 least significant
//   dp_i         decimal point per digit, 1 = lit
//   blank_lz_i   1 = blank leading zeros
//   load_i       single-cycle request to capture digits_i/dp_i/blank_lz_i
//   duty_i       (SSEG_DIMMING_EN only) anode duty, 15 = full on
//   load_done_o  one-cycle pulse when captured data becomes active
//   code_o       code to decoder hex_i, 8'h7F = blank
//   an_o         anode enables, active-low
//   dp_o         decimal point segment, active-low
//
// Optional feature macro: SSEG_DIMMING_EN
//   When this macro is defined, the duty_i port is added. A free-running
//   4-bit PWM counter then gates the selected anode.
module sseg_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [8*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    blank_lz_i,
  input  logic                    load_i,
`ifdef SSEG_DIMMING_EN
  input  logic [3:0]              duty_i,
`endif
  output logic                    load_done_o,
  output logic [7:0]              code_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    dp_o
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_END = DIV_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;
  logic             slot_tick;
  logic             frame_tick;
  logic             in_guard;

  logic [8*NUM_DIGITS-1:0] act_digits;
  logic [8*NUM_DIGITS-1:0] pend_digits;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    act_blz;
  logic                    pend_blz;
  logic                    pend_valid;

  logic [7:0]            shown_code [NUM_DIGITS];
  logic [NUM_DIGITS-1:1] zero_above;  // bit k: digits k..top are all zero
  logic [NUM_DIGITS-1:0] an_sel;

  assign slot_tick  = (div_cnt == DIV_LAST);
  assign frame_tick = slot_tick && (idx == IDX_LAST);
  assign in_guard   = (div_cnt < GUARD_END);
  assign an_sel     = ~(NUM_DIGITS'(1) << idx);

  // Leading-zero blanking. The zero test ripples down from the most
  // significant digit. Digit 0 bypasses it, so a value of all zeros still
  // shows one "0".
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [7:0] raw;
    assign raw = act_digits[8*gi +: 8];
    if (gi == 0) begin : g_lsd
      assign shown_code[gi] = raw;
    end else begin : g_upper
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign zero_above[gi] = (raw == 8'h00);
      end else begin : g_mid
        assign zero_above[gi] = (raw == 8'h00) && zero_above[gi+1];
      end
      assign shown_code[gi] = (act_blz && zero_above[gi]) ? 8'h7F : raw;
    end
  end

  // Slot divider and digit index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (slot_tick) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Double buffer. A load that lands exactly on frame_tick skips the
  // pending buffer, so it is not delayed by a whole extra frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_digits  <= {NUM_DIGITS{8'h7F}};
      act_dp      <= '0;
      act_blz     <= 1'b0;
      pend_digits <= {NUM_DIGITS{8'h7F}};
      pend_dp     <= '0;
      pend_blz    <= 1'b0;
      pend_valid  <= 1'b0;
      load_done_o <= 1'b0;
    end else begin
      load_done_o <= frame_tick && (load_i || pend_valid);
      if (frame_tick) begin
        if (load_i) begin
          act_digits <= digits_i;
          act_dp     <= dp_i;
          act_blz    <= blank_lz_i;
        end else if (pend_valid) begin
          act_digits <= pend_digits;
          act_dp     <= pend_dp;
          act_blz    <= pend_blz;
        end
        pend_valid <= 1'b0;
      end else if (load_i) begin
        pend_digits <= digits_i;
        pend_dp     <= dp_i;
        pend_blz    <= blank_lz_i;
        pend_valid  <= 1'b1;
      end
    end
  end

`ifdef SSEG_DIMMING_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end
`endif

  // Display outputs. They are registered, so they lag div_cnt/idx by one
  // cycle. During the guard window, code_o already carries the slot's code,
  // so the decoder has settled by the time the anode turns on.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      an_o   <= '1;
      code_o <= 8'h7F;
      dp_o   <= 1'b1;
    end else begin
      code_o <= shown_code[idx];
      if (in_guard) begin
        an_o <= '1;
        dp_o <= 1'b1;
      end else begin
`ifdef SSEG_DIMMING_EN
        an_o <= (pwm_cnt <= duty_i) ? an_sel : '1;
`else
        an_o <= an_sel;
`endif
        dp_o <= ~act_dp[idx];
      end
    end
  end

endmodule
